// File: rtl/sysram_arb_pkg.sv
// Shared definitions for the system RAM port-B arbiter.
// Holds the default widths, the requester index encoding and the FSM states.
// No logic beyond a small index-rotation helper.
package sysram_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Requester indices; NONE doubles as the "no owner" grant code.
  typedef enum logic [1:0] {
    PXW  = 2'd0,
    URW  = 2'd1,
    C2H  = 2'd2,
    NONE = 2'd3
  } req_idx_t;

  typedef enum logic {
    ARB      = 1'b0,
    LOCK_C2H = 1'b1
  } state_t;

  // Round-robin successor: PXW -> URW -> C2H -> PXW.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      PXW:     return URW;
      URW:     return C2H;
      default: return PXW;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Purpose: combinational 3-way round-robin pick starting at ptr.
// Latency: zero cycles (pure combinational).
// Backpressure: none; req is sampled as-is every cycle.
// Ports: req[2:0] request vector (bit = requester index), ptr highest-priority
//        index, gnt_idx winning index (NONE when idle), any_gnt winner present.
module rr_arb3
  import sysram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any_gnt
);

  logic [1:0] first;
  logic [1:0] second;
  logic [1:0] third;

  always_comb begin
    // An out-of-range pointer is treated as PXW so the pick is always defined.
    first   = (ptr == NONE) ? PXW : ptr;
    second  = next_idx(first);
    third   = next_idx(second);
    gnt_idx = NONE;
    any_gnt = 1'b0;
    if (req[first]) begin
      gnt_idx = first;
      any_gnt = 1'b1;
    end else if (req[second]) begin
      gnt_idx = second;
      any_gnt = 1'b1;
    end else if (req[third]) begin
      gnt_idx = third;
      any_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/sysram_port_arbiter.sv
// Purpose: share RAM port B between PXIE writes, UART writes and C2H read bursts.
// Latency: transfer in cycle N drives the RAM in N+1; read data returns in N+1+RD_LAT.
// Backpressure: one rdy per cycle; a C2H burst locks the port until its last beat.
// Ports: clk_cpu/rst; pxw_*, urw_* write requesters; c2h_* read requester and
//        return; ram_* registered port-B drive and read data; grant = current owner.
module sysram_port_arbiter
  import sysram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk_cpu,
  input  logic              rst,
  input  logic              pxw_vld,
  input  logic [ADDR_W-1:0] pxw_addr,
  input  logic [DATA_W-1:0] pxw_data,
  output logic              pxw_rdy,
  input  logic              urw_vld,
  input  logic [ADDR_W-1:0] urw_addr,
  input  logic [DATA_W-1:0] urw_data,
  output logic              urw_rdy,
  input  logic              c2h_vld,
  input  logic [ADDR_W-1:0] c2h_addr,
  input  logic              c2h_last,
  output logic              c2h_rdy,
  output logic              c2h_dvld,
  output logic [DATA_W-1:0] c2h_data,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        grant
);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  pick_idx;
  logic        pick_any;
  logic [RD_LAT:0] vld_sr;

  rr_arb3 u_rr_arb3 (
    .req     ({c2h_vld, urw_vld, pxw_vld}),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any_gnt (pick_any)
  );

  // rdy depends only on vld, state and pointer, never on payload. Because each
  // rdy is raised only for a requesting index, grant != NONE means a transfer.
  always_comb begin
    pxw_rdy = 1'b0;
    urw_rdy = 1'b0;
    c2h_rdy = 1'b0;
    grant   = NONE;
    if (!rst) begin
      if (state == LOCK_C2H) begin
        c2h_rdy = c2h_vld;
        if (c2h_vld) grant = C2H;
      end else if (pick_any) begin
        grant   = pick_idx;
        pxw_rdy = (pick_idx == PXW);
        urw_rdy = (pick_idx == URW);
        c2h_rdy = (pick_idx == C2H);
      end
    end
  end

  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      ptr      <= PXW;
      ram_wen  <= 4'h0;
      ram_addr <= '0;
      ram_din  <= '0;
      vld_sr   <= '0;
    end else begin
      // Stage k of vld_sr marks a read whose address left k cycles ago.
      vld_sr  <= {vld_sr[RD_LAT-1:0], (grant == C2H)};
      ram_wen <= 4'h0;
      case (grant)
        PXW: begin
          ram_wen  <= 4'hF;
          ram_addr <= pxw_addr;
          ram_din  <= pxw_data;
          ptr      <= next_idx(PXW);
        end
        URW: begin
          ram_wen  <= 4'hF;
          ram_addr <= urw_addr;
          ram_din  <= urw_data;
          ptr      <= next_idx(URW);
        end
        C2H: begin
          ram_addr <= c2h_addr;
          ptr      <= next_idx(C2H);
          // Same rule in both states: a non-last beat holds the port.
          state    <= c2h_last ? ARB : LOCK_C2H;
        end
        default: begin
        end
      endcase
    end
  end

  assign c2h_dvld = vld_sr[RD_LAT];
  assign c2h_data = ram_dout;

endmodule

// File: tb/tb_sysram_port_arbiter.sv
module tb_sysram_port_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic          clk_cpu;
  logic          rst;
  logic          pxw_vld, urw_vld, c2h_vld, c2h_last;
  logic [AW-1:0] pxw_addr, urw_addr, c2h_addr;
  logic [DW-1:0] pxw_data, urw_data;
  logic          pxw_rdy, urw_rdy, c2h_rdy, c2h_dvld;
  logic [DW-1:0] c2h_data, ram_din, ram_dout;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [1:0]    grant;

  sysram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk_cpu(clk_cpu), .rst(rst),
    .pxw_vld(pxw_vld), .pxw_addr(pxw_addr), .pxw_data(pxw_data), .pxw_rdy(pxw_rdy),
    .urw_vld(urw_vld), .urw_addr(urw_addr), .urw_data(urw_data), .urw_rdy(urw_rdy),
    .c2h_vld(c2h_vld), .c2h_addr(c2h_addr), .c2h_last(c2h_last), .c2h_rdy(c2h_rdy),
    .c2h_dvld(c2h_dvld), .c2h_data(c2h_data),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .grant(grant)
  );

  initial begin
    clk_cpu = 1'b0;
    forever #5 clk_cpu = ~clk_cpu;
  end

  // Behavioural RAM environment with RD_LAT cycles of read latency.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk_cpu) begin
    if (ram_wen == 4'hF) ram_mem[ram_addr] <= ram_din;
    rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RD_LAT-1];

  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_op_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  ram_op_t       ram_q [$];
  rd_exp_t       rd_q  [$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] pool [0:7];
  logic [AW-1:0] m_last_addr;
  int            m_ptr;
  bit            m_lock;
  int            cyc;
  int            n_pass;
  int            n_total;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Reference arbitration: scan requesters from the pointer in fixed order.
  function automatic int model_pick(input logic pv, input logic uv, input logic cv);
    logic [2:0] v;
    v = {cv, uv, pv};
    if (rst) return 3;
    if (m_lock) return cv ? 2 : 3;
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return 3;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Scoreboard side: every negedge compare the registered outputs against queued expectations.
  task automatic monitor_cycle();
    ram_op_t e;
    rd_exp_t r;
    if (ram_q.size() != 0 && ram_q[0].cyc == cyc) begin
      e = ram_q.pop_front();
      chk(ram_wen == (e.wr ? 4'hF : 4'h0), "ram_wen", ram_wen, e.wr ? 4'hF : 4'h0);
      chk(ram_addr == e.addr, "ram_addr", ram_addr, e.addr);
      if (e.wr) chk(ram_din == e.data, "ram_din", ram_din, e.data);
      m_last_addr = e.addr;
    end else begin
      chk(ram_wen == 4'h0, "idle_wen", ram_wen, 0);
      chk(ram_addr == m_last_addr, "idle_addr", ram_addr, m_last_addr);
    end
    if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
      r = rd_q.pop_front();
      chk(c2h_dvld == 1'b1, "dvld_due", c2h_dvld, 1);
      chk(c2h_data == r.data, "c2h_data", c2h_data, r.data);
    end else begin
      chk(c2h_dvld == 1'b0, "dvld_unexpected", c2h_dvld, 0);
    end
  endtask

  // One bus cycle: drive, check arbitration against the model, queue expectations.
  task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic uv, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                      input logic cv, input logic [AW-1:0] ca, input logic cl);
    int w;
    @(posedge clk_cpu); #1;
    pxw_vld = pv; pxw_addr = pa; pxw_data = pd;
    urw_vld = uv; urw_addr = ua; urw_data = ud;
    c2h_vld = cv; c2h_addr = ca; c2h_last = cl;
    @(negedge clk_cpu);
    w = model_pick(pv, uv, cv);
    chk({grant, pxw_rdy, urw_rdy, c2h_rdy} == {2'(w), w == 0, w == 1, w == 2}, "arb",
        {grant, pxw_rdy, urw_rdy, c2h_rdy}, {2'(w), w == 0, w == 1, w == 2});
    case (w)
      0: begin
        ref_mem[pa] = pd;
        ram_q.push_back('{cyc + 1, 1'b1, pa, pd});
        m_ptr = 1;
      end
      1: begin
        ref_mem[ua] = ud;
        ram_q.push_back('{cyc + 1, 1'b1, ua, ud});
        m_ptr = 2;
      end
      2: begin
        ram_q.push_back('{cyc + 1, 1'b0, ca, '0});
        rd_q.push_back('{cyc + 1 + RD_LAT, ref_read(ca)});
        m_ptr = 0;
        m_lock = !cl;
      end
      default: begin
      end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, 0, '0, '0, 0, '0, 0);
  endtask

  // Requests are held high during reset to prove every rdy is forced low.
  task automatic apply_reset(input int n);
    @(posedge clk_cpu); #1;
    rst = 1'b1;
    pxw_vld = 1'b1; urw_vld = 1'b1; c2h_vld = 1'b1; c2h_last = 1'b0;
    ram_q.delete();
    rd_q.delete();
    m_ptr = 0;
    m_lock = 0;
    m_last_addr = '0;
    repeat (n) begin
      @(negedge clk_cpu);
      chk({pxw_rdy, urw_rdy, c2h_rdy} == 3'b000, "rst_rdy", {pxw_rdy, urw_rdy, c2h_rdy}, 0);
      chk(grant == 2'd3, "rst_grant", grant, 3);
      chk(ram_din == '0, "rst_din", ram_din, 0);
    end
    @(posedge clk_cpu); #1;
    rst = 1'b0;
    pxw_vld = 1'b0; urw_vld = 1'b0; c2h_vld = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          pv, uv, cv, cl;
    rst = 1'b1;
    pxw_vld = 0; urw_vld = 0; c2h_vld = 0; c2h_last = 0;
    pxw_addr = '0; urw_addr = '0; c2h_addr = '0; pxw_data = '0; urw_data = '0;
    cyc = 0; n_pass = 0; n_total = 0; m_ptr = 0; m_lock = 0; m_last_addr = '0;
    fork
      forever @(posedge clk_cpu) cyc++;
      forever begin
        @(negedge clk_cpu);
        monitor_cycle();
      end
    join_none

    apply_reset(2);

    // Known write followed by a single-beat read of the same word.
    step(1, 16'h0010, 32'hDEADBEEF, 0, '0, '0, 0, '0, 0);
    step(0, '0, '0, 0, '0, '0, 1, 16'h0010, 1);

    // Fill an address pool so every later read has a known value.
    pool[0] = 16'h0010;
    for (int i = 1; i < 8; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if (i % 2 == 0) step(1, pool[i], d, 0, '0, '0, 0, '0, 0);
      else            step(0, '0, '0, 1, pool[i], d, 0, '0, 0);
    end
    idle(RD_LAT + 2);

    // All three requesting from reset: strict rotation.
    apply_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(1, pool[0], $urandom, 1, pool[1], $urandom, 1, pool[i], 1);
      chk(grant == 2'(i % 3), "rr_seq", grant, i % 3);
    end

    // Four-beat burst while both writers wait, then PXW first.
    step(0, '0, '0, 1, pool[2], $urandom, 0, '0, 0);
    for (int b = 1; b <= 4; b++) begin
      step(1, pool[3], $urandom, 1, pool[4], $urandom, 1, pool[b], (b == 4));
      chk({pxw_rdy, urw_rdy, c2h_rdy} == 3'b001, "burst_lock", {pxw_rdy, urw_rdy, c2h_rdy}, 1);
    end
    step(1, pool[3], $urandom, 1, pool[4], $urandom, 0, '0, 0);
    chk(grant == 2'd0, "post_burst_pxw", grant, 0);

    // Burst with a three-cycle gap: lock holds and the port idles.
    step(0, '0, '0, 0, '0, '0, 1, pool[5], 0);
    for (int g = 0; g < 3; g++) begin
      step(1, pool[6], $urandom, 1, pool[7], $urandom, 0, '0, 0);
      chk(grant == 2'd3, "gap_idle", grant, 3);
    end
    step(1, pool[6], $urandom, 1, pool[7], $urandom, 1, pool[6], 0);
    step(1, pool[6], $urandom, 1, pool[7], $urandom, 1, pool[7], 1);
    idle(RD_LAT + 2);

    // Two reads then reset: returns must be dropped.
    step(0, '0, '0, 0, '0, '0, 1, pool[1], 1);
    step(0, '0, '0, 0, '0, '0, 1, pool[2], 1);
    apply_reset(1);
    idle(RD_LAT + 3);
    step(1, pool[0], $urandom, 1, pool[1], $urandom, 0, '0, 0);
    chk(grant == 2'd0, "ptr_after_rst", grant, 0);

    // Eight back-to-back reads.
    for (int i = 0; i < 8; i++) step(0, '0, '0, 0, '0, '0, 1, pool[i], 1);
    idle(RD_LAT + 2);

    // Random traffic with a reset dropped in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle(1);
        apply_reset(2);
      end
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 2) == 0);
      step(pv, pool[$urandom_range(0, 7)], $urandom,
           uv, pool[$urandom_range(0, 7)], $urandom,
           cv, pool[$urandom_range(0, 7)], cl);
    end
    if (m_lock) step(0, '0, '0, 0, '0, '0, 1, pool[0], 1);
    idle(RD_LAT + 4);
    chk(rd_q.size() == 0 && ram_q.size() == 0, "drain", rd_q.size() + ram_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sysram_port_arbiter.md
SYSRAM_PORT_ARBITER -- requirements
Module: sysram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter RD_LAT, default 1, RAM port read latency in cycles (1..4).
REQ-004 clk_cpu  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pxw_vld / pxw_addr / pxw_data / pxw_rdy  in/in/in/out  1/ADDR_W/DATA_W/1  PXIE write requester.
REQ-007 urw_vld / urw_addr / urw_data / urw_rdy  in/in/in/out  1/ADDR_W/DATA_W/1  UART write requester.
REQ-008 c2h_vld / c2h_addr / c2h_last / c2h_rdy  in/in/in/out  1/ADDR_W/1/1  C2H read requester; c2h_last marks the final beat of a burst.
REQ-009 c2h_dvld / c2h_data  out/out  1/DATA_W  read return.
REQ-010 ram_wen / ram_addr / ram_din  out/out/out  4/ADDR_W/DATA_W  RAM port B drive.
REQ-011 ram_dout  in  DATA_W  RAM port B read data.
REQ-012 grant  out  2  requester owning the current cycle (0 PXW, 1 URW, 2 C2H, 3 none).

Function
REQ-013 Transfer occurs when vld and rdy are both high in the same cycle; at most one rdy is high per cycle.
REQ-014 rdy is combinational from vld, the state and the round-robin pointer; it never depends on its own requester's data.
REQ-015 FSM states: ARB and LOCK_C2H.
REQ-016 In ARB, the winner is the first requesting index starting at the pointer, in the order PXW -> URW -> C2H -> PXW; after a transfer the pointer moves to the index after the winner.
REQ-017 A C2H transfer in ARB with c2h_last=0 moves the FSM to LOCK_C2H; with c2h_last=1 the FSM stays in ARB.
REQ-018 In LOCK_C2H, only c2h_rdy may be high (equal to c2h_vld); writes wait; the FSM returns to ARB on a C2H transfer with c2h_last=1.
REQ-019 In LOCK_C2H with c2h_vld low, the FSM stays locked and the RAM port idles (ram_wen=0).
REQ-020 ram_* outputs are registered: a transfer in cycle N drives the RAM in cycle N+1.
REQ-021 Writes drive ram_wen=4'hF, ram_addr and ram_din; reads and idle cycles drive ram_wen=4'h0; idle keeps the last ram_addr.
REQ-022 c2h_dvld pulses exactly in cycle N+1+RD_LAT for each C2H transfer in cycle N, through a RD_LAT+1 deep valid shift register.
REQ-023 c2h_data equals ram_dout while c2h_dvld is high; back-to-back reads return one beat per cycle, in order, with no backpressure.
REQ-024 The pointer and the state are held in any cycle with no transfer.
REQ-025 Addresses and data pass unmodified; there is no arithmetic or wrap on any path.

Reset
REQ-026 While rst is high: state=ARB, pointer=PXW, ram_wen=0, ram_addr=0, ram_din=0, c2h_dvld=0 (valid shift register cleared), grant=3, and all rdy outputs low.
REQ-027 Asserting rst mid-burst or with reads in flight discards the pending returns; no c2h_dvld follows reset release.

Structure
REQ-028 Package sysram_arb_pkg holds ADDR_W/DATA_W defaults, the requester index constants (PXW, URW, C2H, NONE) and the FSM state encoding.
REQ-029 The combinational 3-way round-robin pick is the sub-module rr_arb3 (inputs req[2:0] and ptr; outputs gnt_idx and any_gnt).

Verification
REQ-030 PXW write addr 0x0010 data 0xDEADBEEF, then C2H read addr 0x0010 last=1 -> ram_wen=F in cycle N+1; c2h_dvld with c2h_data=0xDEADBEEF at cycle M+2 (RD_LAT=1).
REQ-031 All three requesters held high for 6 cycles from reset (C2H last=1) -> grant sequence 0,1,2,0,1,2.
REQ-032 C2H burst of 4 (last on beat 4) with PXW and URW held high -> no write rdy until after beat 4, then PXW granted first.
REQ-033 C2H burst with c2h_vld low for 3 cycles mid-burst -> FSM stays in LOCK_C2H, ram_wen=0, and the burst resumes.
REQ-034 rst pulsed one cycle after 2 back-to-back reads -> no c2h_dvld afterwards; pointer=PXW and grant=3.
REQ-035 RD_LAT=3 with 8 back-to-back reads -> 8 consecutive dvld beats starting 4 cycles after the first transfer, in order.
